// File: rtl/frame_capture_bram0.sv
// Captures one raster-order pixel frame into BRAM0 port 0 and holds it until the Sobel FSM releases it.
// Writes appear one cycle after the accepted beat; s_ready is low outside WAIT_SOF/CAPTURE.
module frame_capture_bram0 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMAGE_W    = 279,
  parameter int IMAGE_H    = 210
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_release,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST_COL = ADDR_WIDTH'(IMAGE_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ROW = ADDR_WIDTH'(IMAGE_H - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_NPIX     = ADDR_WIDTH'(IMAGE_W * IMAGE_H);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE      = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_CAPTURE  = 3'd2,
    S_DONE     = 3'd3,
    S_HOLD     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_we;
  logic                  r_complete;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0] r_baddr;
  logic [DATA_WIDTH-1:0] r_bdata;
  logic [ADDR_WIDTH-1:0] r_num_cnt;

  logic                  w_in_wait;
  logic                  w_in_cap;
  logic                  w_accept;
  logic                  w_take;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [ADDR_WIDTH-1:0] w_row;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_at_eol;
  logic                  w_frame_ok;
  logic                  w_last;
  logic                  w_wr;
  logic                  w_bad;
  logic                  w_arm;
  state_t                w_next;

  assign w_in_wait = (r_state == S_WAIT_SOF);
  assign w_in_cap  = (r_state == S_CAPTURE);
  assign w_accept  = s_valid && r_ready;

  // The SOF beat is position 0 of the frame; junk before it is dropped silently.
  assign w_take = w_accept && ((w_in_wait && s_sof) || (w_in_cap && !s_sof));
  assign w_col  = w_in_wait ? '0 : r_col;
  assign w_row  = w_in_wait ? '0 : r_row;
  assign w_addr = w_in_wait ? '0 : r_addr;

  assign w_at_eol   = (w_col == LP_LAST_COL);
  assign w_frame_ok = (s_eol == w_at_eol);
  assign w_last     = w_at_eol && (w_row == LP_LAST_ROW);
  assign w_wr       = w_take && w_frame_ok;
  assign w_bad      = w_accept && ((w_in_cap && s_sof) || (w_take && !w_frame_ok));
  assign w_arm      = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_WAIT_SOF;
      S_WAIT_SOF: begin
        if (w_bad)     w_next = S_ERR;
        else if (w_wr) w_next = w_last ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_bad)               w_next = S_ERR;
        else if (w_wr && w_last) w_next = S_DONE;
      end
      S_DONE:     w_next = S_HOLD;
      S_HOLD:     if (i_release) w_next = S_IDLE;
      S_ERR:      if (i_start) w_next = S_WAIT_SOF;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_complete <= 1'b0;
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_baddr    <= '0;
      r_bdata    <= '0;
      r_num_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_ready    <= (w_next == S_WAIT_SOF) || (w_next == S_CAPTURE);
      r_busy     <= (w_next != S_IDLE);
      r_we       <= w_wr;
      r_complete <= w_wr && w_last;
      if (w_wr) begin
        r_baddr <= w_addr;
        r_bdata <= s_data;
      end
      if (w_arm) begin
        r_err     <= 1'b0;
        r_addr    <= '0;
        r_col     <= '0;
        r_row     <= '0;
        r_num_cnt <= '0;
      end else if (w_wr) begin
        // The address stops at the final pixel so it never reaches IMAGE_W*IMAGE_H.
        if (!w_last) r_addr <= w_addr + LP_ONE;
        if (w_at_eol) begin
          r_col <= '0;
          r_row <= w_row + LP_ONE;
        end else begin
          r_col <= w_col + LP_ONE;
          r_row <= w_row;
        end
        if (w_last) r_num_cnt <= LP_NPIX;
      end
      if (w_bad) r_err <= 1'b1;
    end
  end

  assign s_ready    = r_ready;
  assign b0_ce0     = r_we;
  assign b0_we0     = r_we;
  assign b0_addr0   = r_baddr;
  assign b0_d0      = r_bdata;
  assign o_complete = r_complete;
  assign o_num_cnt  = r_num_cnt;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_frame_capture_bram0.sv
// Bench for frame_capture_bram0: a 4x3 instance checked against a pixel-index model, plus a full default-size frame.
module tb_frame_capture_bram0;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int BW = 279;
  localparam int BH = 210;
  localparam int BN = BW * BH;

  localparam int MI = 0, MW = 1, MC = 2, MD = 3, MH = 4, ME = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        i_start = 0, i_release = 0, s_valid = 0, s_sof = 0, s_eol = 0;
  logic [7:0]  s_data = 0;
  logic        s_ready, b0_ce0, b0_we0, o_complete, o_busy, o_err;
  logic [15:0] b0_addr0, o_num_cnt;
  logic [7:0]  b0_d0;

  logic        g_start = 0, g_release = 0, g_valid = 0, g_sof = 0, g_eol = 0;
  logic [7:0]  g_data = 0;
  logic        g_ready, g_ce, g_we, g_complete, g_busy, g_err;
  logic [15:0] g_addr, g_num;
  logic [7:0]  g_d;

  frame_capture_bram0 #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_release(i_release),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0), .b0_d0(b0_d0),
    .o_complete(o_complete), .o_num_cnt(o_num_cnt), .o_busy(o_busy), .o_err(o_err)
  );

  frame_capture_bram0 dut_big (
    .clk(clk), .rst_n(rst_n), .i_start(g_start), .i_release(g_release),
    .s_valid(g_valid), .s_ready(g_ready), .s_data(g_data), .s_sof(g_sof), .s_eol(g_eol),
    .b0_ce0(g_ce), .b0_we0(g_we), .b0_addr0(g_addr), .b0_d0(g_d),
    .o_complete(g_complete), .o_num_cnt(g_num), .o_busy(g_busy), .o_err(g_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the frame position is a single pixel index; line ends fall where index % W == W-1.
  int   m_mode = MI, m_pix = 0, m_addr = 0, m_data = 0, m_num = 0;
  logic m_ready = 0, m_we = 0, m_complete = 0, m_busy = 0, m_err = 0;
  logic m_acc;
  int   wr_cnt = 0, cmp_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = MI; m_pix = 0; m_addr = 0; m_data = 0; m_num = 0;
      m_ready = 0; m_we = 0; m_complete = 0; m_busy = 0; m_err = 0;
    end else begin
      m_acc = s_valid && m_ready;
      m_we = 0;
      m_complete = 0;
      case (m_mode)
        MI: if (i_start) begin m_mode = MW; m_pix = 0; m_num = 0; end
        MW, MC: if (m_acc) begin
          if (s_sof && m_mode == MC) begin
            m_mode = ME; m_err = 1;
          end else if (s_sof || m_mode == MC) begin
            if (s_eol != ((m_pix % W) == W - 1)) begin
              m_mode = ME; m_err = 1;
            end else begin
              m_we = 1; m_addr = m_pix; m_data = s_data; m_pix++;
              if (m_pix == N) begin m_mode = MD; m_complete = 1; m_num = N; end
              else m_mode = MC;
            end
          end
        end
        MD: m_mode = MH;
        MH: if (i_release) m_mode = MI;
        ME: if (i_start) begin m_mode = MW; m_err = 0; m_pix = 0; m_num = 0; end
        default: m_mode = MI;
      endcase
      m_ready = (m_mode == MW) || (m_mode == MC);
      m_busy  = (m_mode != MI);
    end
    #1;
    check("s_ready", s_ready, m_ready);
    check("b0_we0", b0_we0, m_we);
    check("b0_ce0", b0_ce0, m_we);
    check("b0_addr0", b0_addr0, m_addr);
    check("b0_d0", b0_d0, m_data);
    check("o_complete", o_complete, m_complete);
    check("o_num_cnt", o_num_cnt, m_num);
    check("o_busy", o_busy, m_busy);
    check("o_err", o_err, m_err);
    if (b0_we0 === 1'b1) wr_cnt++;
    if (o_complete === 1'b1) cmp_cnt++;
  end

  int g_exp = 0, g_cmp = 0, g_last = 0;
  always @(posedge clk) begin
    #1;
    if (g_we === 1'b1) begin
      check("big_addr", g_addr, g_exp);
      check("big_data", g_d, g_exp & 255);
      g_last = g_addr;
      g_exp++;
    end
    if (g_complete === 1'b1) g_cmp++;
  end

  task automatic idle();
    s_valid = 0; s_sof = 0; s_eol = 0;
  endtask

  task automatic pulse_start();
    i_start = 1; @(negedge clk); i_start = 0;
  endtask

  task automatic pulse_release();
    i_release = 1; @(negedge clk); i_release = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eol, input int gap);
    bit done;
    done = 0;
    repeat (gap) begin idle(); @(negedge clk); end
    s_valid = 1; s_data = d; s_sof = sof; s_eol = eol;
    for (int t = 0; t < 100 && !done; t++) begin
      if (s_ready) done = 1;
      @(negedge clk);
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] base, input int maxgap);
    for (int i = 0; i < N; i++)
      send(base + 8'(i), i == 0, (i % W) == W - 1, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", s_ready, 0);
    check("rst_we", b0_we0, 0);
    check("rst_addr", b0_addr0, 0);
    check("rst_num", o_num_cnt, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    rst_n = 1;
    @(negedge clk);

    // Nominal frame
    wr_cnt = 0; cmp_cnt = 0;
    pulse_start();
    check("arm_ready", s_ready, 1);
    send_frame(8'h10, 0);
    check("nom_complete", o_complete, 1);
    check("nom_last_we", b0_we0, 1);
    check("nom_last_addr", b0_addr0, 11);
    check("nom_last_data", b0_d0, 8'h1B);
    check("nom_num", o_num_cnt, 12);
    idle();
    @(negedge clk);
    check("nom_writes", wr_cnt, 12);
    check("nom_cmp_once", cmp_cnt, 1);
    check("nom_hold_ready", s_ready, 0);
    check("nom_err", o_err, 0);
    pulse_release();

    // Junk before SOF, random gaps
    wr_cnt = 0; cmp_cnt = 0;
    pulse_start();
    send(8'hAA, 0, 0, 1);
    send(8'hAB, 0, 1, 0);
    send(8'hAC, 0, 0, 2);
    send_frame(8'h30, 3);
    idle();
    @(negedge clk);
    check("junk_writes", wr_cnt, 12);
    check("junk_cmp_once", cmp_cnt, 1);
    check("junk_last_data", b0_d0, 8'h3B);
    pulse_release();

    // Early end of line
    wr_cnt = 0;
    pulse_start();
    send(8'h10, 1, 0, 0);
    send(8'h11, 0, 0, 0);
    send(8'h12, 0, 1, 0);
    idle();
    check("eol_err", o_err, 1);
    check("eol_ready", s_ready, 0);
    check("eol_writes", wr_cnt, 2);
    check("eol_addr_held", b0_addr0, 1);
    pulse_start();
    check("rearm_err", o_err, 0);
    check("rearm_ready", s_ready, 1);
    send_frame(8'h40, 0);
    check("rearm_complete", o_complete, 1);
    check("rearm_data", b0_d0, 8'h4B);
    idle();
    @(negedge clk);

    // Buffer hold: a second frame is refused until release
    wr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1; s_data = 8'h80 + 8'(i); s_sof = (i == 0); s_eol = ((i % W) == W - 1);
      i_start = (i == 5);
      @(negedge clk);
    end
    i_start = 0;
    idle();
    check("hold_writes", wr_cnt, 0);
    check("hold_ready", s_ready, 0);
    check("hold_busy", o_busy, 1);
    check("hold_num", o_num_cnt, 12);
    pulse_release();
    check("rel_busy", o_busy, 0);
    pulse_start();
    check("second_num_cleared", o_num_cnt, 0);
    cmp_cnt = 0;
    send_frame(8'h50, 1);
    idle();
    @(negedge clk);
    check("second_cmp", cmp_cnt, 1);
    check("second_num", o_num_cnt, 12);
    pulse_release();

    // Reset mid-frame
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), i == 0, (i % W) == W - 1, 0);
    rst_n = 0;
    #1;
    check("mrst_ready", s_ready, 0);
    check("mrst_we", b0_we0, 0);
    check("mrst_addr", b0_addr0, 0);
    check("mrst_data", b0_d0, 0);
    check("mrst_busy", o_busy, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pulse_start();
    send_frame(8'h60, 0);
    check("post_rst_num", o_num_cnt, 12);
    check("post_rst_addr", b0_addr0, 11);
    idle();
    @(negedge clk);
    pulse_release();

    // Full default-size frame
    g_start = 1; @(negedge clk); g_start = 0;
    for (int i = 0; i < BN; i++) begin
      bit done;
      done = 0;
      g_valid = 1; g_data = 8'(i); g_sof = (i == 0); g_eol = ((i % BW) == BW - 1);
      for (int t = 0; t < 100 && !done; t++) begin
        if (g_ready) done = 1;
        @(negedge clk);
      end
      if (!done) begin
        check("big_timeout", 0, 1);
        break;
      end
    end
    g_valid = 0; g_sof = 0; g_eol = 0;
    repeat (3) @(negedge clk);
    check("big_num", g_num, BN);
    check("big_writes", g_exp, BN);
    check("big_last_addr", g_last, BN - 1);
    check("big_cmp_once", g_cmp, 1);
    check("big_err", g_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_capture_bram0.md
Name: frame_capture_bram0

Overview:
- Upstream stage of the Sobel edge detector.
- Accepts a raster-order 8-bit pixel stream through a valid/ready handshake with start-of-frame and end-of-line markers.
- Writes one full frame into BRAM0 through its port 0. Port 1 is owned by the Sobel FSM.
- Reports frame completion and pixel count to the Sobel FSM, then holds the buffer until the Sobel FSM releases it.

Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 16, BRAM0 address width and count width. Must hold IMAGE_W*IMAGE_H.
- IMAGE_W, 279, pixels per line.
- IMAGE_H, 210, lines per frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  arm capture of one frame (1-cycle pulse)
- i_release  in  1  Sobel FSM finished with BRAM0; frees the buffer
- s_valid  in  1  pixel beat valid
- s_ready  out  1  block accepts beat
- s_data  in  DATA_WIDTH  pixel value
- s_sof  in  1  beat is first pixel of frame
- s_eol  in  1  beat is last pixel of a line
- b0_ce0  out  1  BRAM0 port-0 enable
- b0_we0  out  1  BRAM0 port-0 write enable
- b0_addr0  out  ADDR_WIDTH  BRAM0 port-0 address
- b0_d0  out  DATA_WIDTH  BRAM0 port-0 write data
- o_complete  out  1  1-cycle pulse: frame fully written (drives Sobel i_complete)
- o_num_cnt  out  ADDR_WIDTH  pixels written (drives Sobel i_num_cnt)
- o_busy  out  1  state is not IDLE
- o_err  out  1  sticky framing error

Behaviour:
- A beat is accepted on a rising edge where s_valid && s_ready.
- Reset values:
  - state = IDLE; all outputs 0; internal address counter 0; column counter 0; row counter 0.
- States and transitions:
  - IDLE: s_ready=0. i_start -> WAIT_SOF.
  - WAIT_SOF: s_ready=1.
    - Accepted beats with s_sof=0 are discarded, with no write.
    - An accepted beat with s_sof=1 is written to address 0; col=1, row=0; -> CAPTURE.
    - If IMAGE_W=1 and s_eol=1 on that beat, it is treated as an end of line as in CAPTURE.
  - CAPTURE: s_ready=1. Each accepted beat is written at the address counter, then the counter is incremented.
    - s_sof=1 on an accepted beat -> ERR. The beat is not written.
    - s_eol=1 with col != IMAGE_W-1 -> ERR. The beat is not written.
    - col == IMAGE_W-1 with s_eol=0 -> ERR. The beat is not written.
    - Valid end of line: col=0, row+1.
    - Valid end of line with row == IMAGE_H-1 is the last pixel: it is written, then -> DONE.
  - DONE: single cycle. o_complete=1; o_num_cnt=IMAGE_W*IMAGE_H; s_ready=0; -> HOLD.
  - HOLD: s_ready=0; o_num_cnt held. i_release -> IDLE. i_start is ignored.
  - ERR: s_ready=0; o_err=1. i_start -> WAIT_SOF; clears o_err and all counters. i_release is ignored.
- i_start outside IDLE and ERR is ignored.
- BRAM write timing:
  - Write port outputs are registered.
  - A beat accepted at edge N gives b0_ce0=b0_we0=1 with address and data in the cycle after edge N. They are 0 otherwise.
  - b0_d0 and b0_addr0 hold their last values when the strobe is 0.
  - The last pixel's write strobe and the o_complete pulse occur in the same cycle (DONE).
- o_num_cnt: 0 from reset and from i_start; loaded on entry to DONE; held until the next i_start.
- No address wrap: the counter never exceeds IMAGE_W*IMAGE_H-1, because framing checks force ERR first.
- s_valid low in any state: no state change, no write. Gaps of arbitrary length are tolerated.
- Reset asserted mid-capture: immediate return to reset values. A write strobe in flight is dropped. BRAM0 contents are undefined.

Test Plan:
All scenarios use IMAGE_W=4, IMAGE_H=3 unless stated.
- Nominal frame: i_start, then 12 beats with data 0x10..0x1B, s_sof on beat 0, s_eol on beats 3, 7, 11 -> writes to addr 0..11 with data 0x10..0x1B. o_complete is a single pulse coincident with the addr 11 write. o_num_cnt=12. o_err=0.
- Pre-SOF junk and gaps: 3 beats without s_sof, then the nominal frame with random s_valid gaps -> junk is not written, exactly 12 writes, o_complete once.
- Early EOL: s_eol on beat 2 -> no write for beat 2, o_err=1, s_ready=0. A following i_start -> o_err=0 and s_ready=1; a nominal frame then completes.
- Buffer hold: nominal frame, then a second frame driven with no i_release -> s_ready stays 0 and there are no writes. i_release -> IDLE; i_start -> second frame captured.
- Reset mid-frame: rst_n low after 5 accepted beats -> all outputs 0 immediately. After release plus i_start, a nominal frame completes with o_num_cnt=12.
- Default parameters (279x210): full frame -> o_num_cnt=58590, last write addr=58589, exactly one o_complete.
